// File: rtl/program_counter_ras_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the fetch program counter and its return-address
// stack: redirect-select encoding, instruction size and the default trap
// vector. No ports (package).
// -----------------------------------------------------------------------------
package pc_pkg;

   localparam int unsigned INST_BYTES          = 4;
   localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0100;

   typedef enum logic [2:0] {
      SEQ    = 3'd0,
      BRANCH = 3'd1,
      JAL    = 3'd2,
      JALR   = 3'd3,
      TRAP   = 3'd4,
      RET    = 3'd5
   } pc_sel_t;

   // Encodings 6 and 7 are not redirects; they fold onto sequential fetch.
   function automatic pc_sel_t decode_sel(input logic [2:0] raw);
      if (raw > 3'd5) begin
         return SEQ;
      end
      return pc_sel_t'(raw);
   endfunction

endpackage : pc_pkg

// File: rtl/program_counter_ras_ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Circular LIFO used as a return-address stack. A push onto a full stack
// overwrites the oldest entry; a pop of an empty stack is ignored. Push and
// pop in the same cycle replace the top entry.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset (pointer and count only)
//   push       in   write push_data as the new top
//   pop        in   discard the top entry
//   push_data  in   WIDTH-bit value to push
//   top        out  current top entry (valid when !empty)
//   count      out  number of live entries, saturates at DEPTH
//   empty      out  count == 0
// -----------------------------------------------------------------------------
module ras_stack #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               push_data,
   output logic [WIDTH-1:0]               top,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;      // next free slot
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] top_idx;
   logic [PTR_W-1:0] wr_idx;
   logic             wr_en;
   logic             do_pop;

   // DEPTH is a power of two, so pointer arithmetic wraps for free.
   assign top_idx = ptr_q - 1'b1;
   assign do_pop  = pop && (count_q != '0);

   // NOTE: every always_comb output gets a default before any branch so no
   // path leaves it unassigned and a latch is never inferred.
   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      wr_en   = 1'b0;
      wr_idx  = ptr_q;
      if (do_pop && push) begin
         // Pop then push: the top slot is simply rewritten.
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (do_pop) begin
         ptr_d   = ptr_q - 1'b1;
         count_d = count_q - 1'b1;
      end else if (push) begin
         wr_en  = 1'b1;
         wr_idx = ptr_q;
         ptr_d  = ptr_q + 1'b1;
         if (count_q != FULL) begin
            count_d = count_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples its inputs from before the clock edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; count gates every
   // read, so stale contents are never observed and the RAM stays reset-free.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= push_data;
      end
   end

   assign top   = mem_q[top_idx];
   assign count = count_q;
   assign empty = (count_q == '0);

endmodule : ras_stack

// File: rtl/program_counter_ras.sv
// -----------------------------------------------------------------------------
// program_counter_ras
// Fetch-stage program counter. Selects the next fetch address from six
// redirect modes, traps misaligned redirect targets, buffers one redirect that
// arrives while the L1 instruction cache is stalled, and optionally predicts
// returns with a return-address stack.
//
// Build option: define PROGRAM_COUNTER_RAS_EN to build the return-address
// stack. Without it RET behaves as JALR, call_push is ignored and ras_underflow
// is tied low.
//
// Ports:
//   clk                in   system clock, rising edge
//   reset              in   synchronous active-low reset
//   L1_busy            in   instruction cache stall, PC holds while high
//   pc_select          in   0 SEQ, 1 BRANCH, 2 JAL, 3 JALR, 4 TRAP, 5 RET
//   call_push          in   with JAL/JALR/RET: push pc_plus_four_next
//   alu_result         in   branch offset or JALR target
//   jal_address        in   absolute JAL target
//   pc_next            out  current fetch PC (registered)
//   pc_plus_four_next  out  pc_next + 4, combinational, wraps
//   redirect_pending   out  a redirect is buffered awaiting !L1_busy
//   misalign_trap      out  pulse alongside a PC update caused by a misaligned target
//   ras_underflow      out  pulse after a RET executed with the stack empty
// -----------------------------------------------------------------------------
module program_counter_ras
   import pc_pkg::*;
#(
   parameter int unsigned          pc_size      = 32,
   parameter logic [pc_size-1:0]   RESET_VECTOR = '0,
   parameter logic [pc_size-1:0]   TRAP_VECTOR  = pc_size'(DEFAULT_TRAP_VECTOR),
   parameter int unsigned          RAS_DEPTH    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               L1_busy,
   input  logic [2:0]         pc_select,
   input  logic               call_push,
   input  logic [pc_size-1:0] alu_result,
   input  logic [pc_size-1:0] jal_address,
   output logic [pc_size-1:0] pc_next,
   output logic [pc_size-1:0] pc_plus_four_next,
   output logic               redirect_pending,
   output logic               misalign_trap,
   output logic               ras_underflow
);

   localparam logic [pc_size-1:0] STEP      = pc_size'(INST_BYTES);
   localparam logic [pc_size-1:0] BIT0_MASK = ~pc_size'(1);

   pc_sel_t            sel;
   logic [pc_size-1:0] pc_q, pc_d;
   logic [pc_size-1:0] pend_target_q, pend_target_d;
   logic               pend_valid_q, pend_valid_d;
   logic               pend_trap_q, pend_trap_d;
   logic               pend_mis_q, pend_mis_d;
   logic               mis_q, mis_d;
   logic               unf_q, unf_d;

   logic [pc_size-1:0] raw_target;
   logic [pc_size-1:0] res_target;
   logic [pc_size-1:0] ret_target;
   logic               cur_redirect;
   logic               cur_wins;
   logic               cur_mis;
   logic               underflow_now;

   assign sel               = decode_sel(pc_select);
   assign pc_plus_four_next = pc_q + STEP;

   // A current redirect is taken (applied, or captured during a stall) unless
   // a buffered TRAP is waiting; the return stack moves only on that event,
   // so a redirect that is later replayed from the buffer never touches it
   // again.
   assign cur_redirect = (sel != SEQ);
   assign cur_wins     = cur_redirect && !(pend_valid_q && pend_trap_q);

`ifdef PROGRAM_COUNTER_RAS_EN
   logic                           ras_push;
   logic                           ras_pop;
   logic                           ras_empty;
   logic [pc_size-1:0]             ras_top;
   logic [$clog2(RAS_DEPTH+1)-1:0] unused_ras_count;

   assign ras_push = cur_wins && call_push && (sel inside {JAL, JALR, RET});
   assign ras_pop  = cur_wins && (sel == RET);

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (pc_size)
   ) u_ras_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus_four_next),
      .top       (ras_top),
      .count     (unused_ras_count),
      .empty     (ras_empty)
   );

   // An empty stack falls back to the JALR-style target.
   assign ret_target    = ras_empty ? (alu_result & BIT0_MASK) : ras_top;
   assign underflow_now = ras_pop && ras_empty;
`else
   logic unused_call_push;

   assign unused_call_push = call_push;
   assign ret_target       = alu_result & BIT0_MASK;
   assign underflow_now    = 1'b0;
`endif

   always_comb begin
      raw_target = pc_plus_four_next;
      unique case (sel)
         BRANCH:  raw_target = pc_q + alu_result;
         JAL:     raw_target = jal_address;
         JALR:    raw_target = alu_result & BIT0_MASK;
         TRAP:    raw_target = TRAP_VECTOR;
         RET:     raw_target = ret_target;
         default: raw_target = pc_plus_four_next;
      endcase
   end

   assign cur_mis    = cur_redirect && (raw_target[1:0] != 2'b00);
   assign res_target = cur_mis ? TRAP_VECTOR : raw_target;

   always_comb begin
      pc_d          = pc_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      pend_trap_d   = pend_trap_q;
      pend_mis_d    = pend_mis_q;
      mis_d         = 1'b0;
      unf_d         = underflow_now;
      if (L1_busy) begin
         // Stalled: only capture; the youngest redirect overwrites the buffer.
         if (cur_wins) begin
            pend_valid_d  = 1'b1;
            pend_target_d = res_target;
            pend_trap_d   = (sel == TRAP);
            pend_mis_d    = cur_mis;
         end
      end else begin
         // Whatever happens, the buffer is consumed or superseded this cycle.
         pend_valid_d = 1'b0;
         pend_trap_d  = 1'b0;
         pend_mis_d   = 1'b0;
         if (cur_wins) begin
            pc_d  = res_target;
            mis_d = cur_mis;
         end else if (pend_valid_q) begin
            pc_d  = pend_target_q;
            mis_d = pend_mis_q;
         end else begin
            pc_d = pc_plus_four_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q          <= RESET_VECTOR;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         pend_trap_q   <= 1'b0;
         pend_mis_q    <= 1'b0;
         mis_q         <= 1'b0;
         unf_q         <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         pend_trap_q   <= pend_trap_d;
         pend_mis_q    <= pend_mis_d;
         mis_q         <= mis_d;
         unf_q         <= unf_d;
      end
   end

   assign pc_next          = pc_q;
   assign redirect_pending = pend_valid_q;
   assign misalign_trap    = mis_q;
   assign ras_underflow    = unf_q;

endmodule : program_counter_ras

// File: tb/tb_program_counter_ras.sv
// -----------------------------------------------------------------------------
// tb_program_counter_ras
// Directed bench for program_counter_ras (pc_size=32, RESET_VECTOR=0,
// TRAP_VECTOR=0x100, RAS_DEPTH=4). A queue-based reference model tracks the
// expected PC, pending buffer and return stack; a negedge process compares
// every output against it each cycle, and the stimulus sequence pins the
// model with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_program_counter_ras;
   import pc_pkg::*;

   localparam int unsigned  RAS_D  = 4;
   localparam logic [31:0]  TRAP_V = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        L1_busy;
   logic [2:0]  pc_select;
   logic        call_push;
   logic [31:0] alu_result;
   logic [31:0] jal_address;
   logic [31:0] pc_next;
   logic [31:0] pc_plus_four_next;
   logic        redirect_pending;
   logic        misalign_trap;
   logic        ras_underflow;

   always #5 clk = ~clk;

   program_counter_ras #(
      .pc_size      (32),
      .RESET_VECTOR (32'h0),
      .TRAP_VECTOR  (TRAP_V),
      .RAS_DEPTH    (RAS_D)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .L1_busy           (L1_busy),
      .pc_select         (pc_select),
      .call_push         (call_push),
      .alu_result        (alu_result),
      .jal_address       (jal_address),
      .pc_next           (pc_next),
      .pc_plus_four_next (pc_plus_four_next),
      .redirect_pending  (redirect_pending),
      .misalign_trap     (misalign_trap),
      .ras_underflow     (ras_underflow)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_pc;
   logic [31:0] m_pt;
   bit          m_pv, m_ptrap, m_pmis, m_mis, m_unf;
   logic [31:0] ras_q [$];
   bit          model_live = 1'b0;

   task automatic exec_redirect(input int s, input bit push, input logic [31:0] alu,
                                input logic [31:0] jal, output logic [31:0] tgt,
                                output bit mis, output bit unf);
      logic [31:0] raw;
      unf = 1'b0;
      case (s)
         1:       raw = m_pc + alu;
         2:       raw = jal;
         3:       raw = alu & 32'hFFFF_FFFE;
         4:       raw = TRAP_V;
         default: begin
`ifdef PROGRAM_COUNTER_RAS_EN
            if (ras_q.size() == 0) begin
               raw = alu & 32'hFFFF_FFFE;
               unf = 1'b1;
            end else begin
               raw = ras_q.pop_back();
            end
`else
            raw = alu & 32'hFFFF_FFFE;
`endif
         end
      endcase
`ifdef PROGRAM_COUNTER_RAS_EN
      if (push && (s == 2 || s == 3 || s == 5)) begin
         ras_q.push_back(m_pc + 32'd4);
         if (ras_q.size() > RAS_D) void'(ras_q.pop_front());
      end
`endif
      mis = (raw[1:0] != 2'b00);
      tgt = mis ? TRAP_V : raw;
   endtask

   task automatic model_step(input bit rst_n, input bit busy, input int sel, input bit push,
                             input logic [31:0] alu, input logic [31:0] jal);
      int          s;
      bit          take;
      logic [31:0] t;
      bit          mis, unf;
      if (!rst_n) begin
         m_pc = 32'h0; m_pv = 0; m_ptrap = 0; m_pmis = 0; m_mis = 0; m_unf = 0;
         ras_q.delete();
         model_live = 1'b1;
         return;
      end
      s = (sel > 5) ? 0 : sel;
      m_mis = 0;
      m_unf = 0;
      t = 32'h0; mis = 0; unf = 0;
      take = (s != 0) && !(m_pv && m_ptrap);
      if (take) exec_redirect(s, push, alu, jal, t, mis, unf);
      m_unf = unf;
      if (busy) begin
         if (take) begin
            m_pv = 1; m_pt = t; m_ptrap = (s == 4); m_pmis = mis;
         end
      end else begin
         if (take)      begin m_pc = t;    m_mis = mis;    end
         else if (m_pv) begin m_pc = m_pt; m_mis = m_pmis; end
         else           m_pc = m_pc + 32'd4;
         m_pv = 0; m_ptrap = 0; m_pmis = 0;
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, return #1 later.
   task automatic step(input bit rst_n, input bit busy, input pc_sel_t sel, input bit push,
                       input logic [31:0] alu, input logic [31:0] jal);
      reset       = rst_n;
      L1_busy     = busy;
      pc_select   = sel;
      call_push   = push;
      alu_result  = alu;
      jal_address = jal;
      @(posedge clk);
      model_step(rst_n, busy, int'(sel), push, alu, jal);
      #1;
   endtask

   // Raw select encoding (for the 6/7 alias).
   task automatic step_raw(input logic [2:0] raw_sel);
      reset = 1'b1; L1_busy = 1'b0; pc_select = raw_sel; call_push = 1'b0;
      alu_result = 32'h0; jal_address = 32'h0;
      @(posedge clk);
      model_step(1'b1, 1'b0, int'(raw_sel), 1'b0, 32'h0, 32'h0);
      #1;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (model_live) begin
         check("pc_next",           pc_next,                   m_pc);
         check("pc_plus_four_next", pc_plus_four_next,         m_pc + 32'd4);
         check("redirect_pending",  32'(redirect_pending),     32'(m_pv));
         check("misalign_trap",     32'(misalign_trap),        32'(m_mis));
         check("ras_underflow",     32'(ras_underflow),        32'(m_unf));
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      step(0, 0, SEQ, 0, 0, 0);
      step(0, 0, SEQ, 0, 0, 0);
      check("reset_pc", pc_next, 32'h0);
      check("reset_pending", 32'(redirect_pending), 32'h0);
      check("reset_pulses", 32'({misalign_trap, ras_underflow}), 32'h0);

      step(1, 0, SEQ, 0, 0, 0);  check("seq_4",  pc_next, 32'd4);
      step(1, 0, SEQ, 0, 0, 0);  check("seq_8",  pc_next, 32'd8);
      step(1, 0, SEQ, 0, 0, 0);  check("seq_12", pc_next, 32'd12);
      check("plus_four_16", pc_plus_four_next, 32'd16);

      step(1, 0, BRANCH, 0, 32'd36, 0);         check("branch_fwd", pc_next, 32'd48);
      step(1, 0, BRANCH, 0, 32'hFFFF_FFF0, 0);  check("branch_back", pc_next, 32'd32);

      step(1, 1, JAL, 0, 0, 32'd120);
      check("stall_hold", pc_next, 32'd32);
      check("stall_pending", 32'(redirect_pending), 32'h1);
      step(1, 0, SEQ, 0, 0, 0);
      check("release_pc", pc_next, 32'd120);
      check("release_clear", 32'(redirect_pending), 32'h0);

      step(1, 0, JALR, 0, 32'hFFFF_FFF3, 0);
      check("misalign_pc", pc_next, 32'h100);
      check("misalign_pulse", 32'(misalign_trap), 32'h1);
      step(1, 0, SEQ, 0, 0, 0);
      check("misalign_drop", 32'(misalign_trap), 32'h0);
      check("after_trap_pc", pc_next, 32'h104);

      // Return-address stack
      step(1, 0, JAL, 0, 0, 32'h40);
      step(1, 0, JAL, 1, 0, 32'h200);
      step(1, 0, RET, 0, 32'h500, 0);
`ifdef PROGRAM_COUNTER_RAS_EN
      check("ret_44", pc_next, 32'h44);
`else
      check("ret_as_jalr", pc_next, 32'h500);
`endif
      for (int i = 0; i < 5; i++) step(1, 0, JAL, 1, 0, 32'h1000 + 32'h100 * i);
      for (int i = 0; i < 4; i++) step(1, 0, RET, 0, 32'h800, 0);
`ifdef PROGRAM_COUNTER_RAS_EN
      check("ras_oldest_lost", pc_next, 32'h1004);
`endif
      step(1, 0, RET, 0, 32'h800, 0);
      check("underflow_pc", pc_next, 32'h800);
`ifdef PROGRAM_COUNTER_RAS_EN
      check("underflow_pulse", 32'(ras_underflow), 32'h1);
`endif
      step(1, 0, JAL, 1, 0, 32'h900);
      step(1, 0, RET, 1, 32'h0, 0);
`ifdef PROGRAM_COUNTER_RAS_EN
      check("ret_push_pc", pc_next, 32'h804);
`endif
      step(1, 0, RET, 0, 32'h0, 0);
`ifdef PROGRAM_COUNTER_RAS_EN
      check("ret_push_top", pc_next, 32'h904);
`endif
      // Push captured during a stall must happen exactly once.
      step(1, 0, JAL, 0, 0, 32'hA00);
      step(1, 1, JAL, 1, 0, 32'h300);
      step(1, 1, SEQ, 0, 0, 0);
      step(1, 0, SEQ, 0, 0, 0);
      check("stall_call_pc", pc_next, 32'h300);
      step(1, 0, RET, 0, 32'h10, 0);
`ifdef PROGRAM_COUNTER_RAS_EN
      check("stall_call_ret", pc_next, 32'hA04);
`endif
      step(1, 0, RET, 0, 32'h10, 0);
      check("single_push_pc", pc_next, 32'h10);

      // TRAP in the buffer survives later redirects.
      step(1, 1, JAL, 0, 0, 32'h600);
      step(1, 1, TRAP, 0, 0, 0);
      step(1, 1, BRANCH, 0, 32'd8, 0);
      check("trap_hold", pc_next, 32'h10);
      step(1, 0, SEQ, 0, 0, 0);
      check("trap_wins", pc_next, TRAP_V);
      step(1, 1, TRAP, 0, 0, 0);
      step(1, 0, JAL, 0, 0, 32'h700);
      check("trap_beats_current", pc_next, TRAP_V);
      step(1, 1, JAL, 0, 0, 32'h600);
      step(1, 0, BRANCH, 0, 32'd8, 0);
      check("youngest_wins", pc_next, 32'h108);
      step_raw(3'd7);
      check("sel7_is_seq", pc_next, 32'h10C);

      // Misaligned target captured during a stall.
      step(1, 1, BRANCH, 0, 32'd2, 0);
      step(1, 0, SEQ, 0, 0, 0);
      check("pend_mis_pc", pc_next, TRAP_V);
      check("pend_mis_pulse", 32'(misalign_trap), 32'h1);

      // Reset while a redirect is buffered.
      step(1, 1, JAL, 0, 0, 32'h600);
      check("pre_reset_pending", 32'(redirect_pending), 32'h1);
      step(0, 1, SEQ, 0, 0, 0);
      check("mid_reset_pc", pc_next, 32'h0);
      check("mid_reset_pending", 32'(redirect_pending), 32'h0);
      step(1, 0, SEQ, 0, 0, 0);
      check("post_reset_seq", pc_next, 32'h4);

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_program_counter_ras
